fp32_to_bf16_packer: RTL and testbench

Write-back narrowing stage for the BF16 systolic array. It accepts a stream of FP32 partial sums from the PE accumulator (the FP32 adder output) and rounds each one to BF16 using round-to-nearest-even. It then packs two BF16 results into one 32-bit word for the output SRAM. The block has a valid/ready handshake on both sides, a flush request that emits a half-filled word, and a saturating inexact-result counter.

---
 rtl/fp32_to_bf16_packer_if.sv | 31 +++
 rtl/fp32_to_bf16_packer.sv | 127 ++++++++++++
 tb/tb_fp32_to_bf16_packer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/fp32_to_bf16_packer_if.sv
// Handshake bundle for the FP32 -> BF16 write-back packer.
//   in_data/in_valid/in_ready    : FP32 input stream
//   flush/flush_ack              : request to emit a held half-word
//   out_word/out_lanes/out_valid/out_ready : packed BF16 output stream
// master: the surrounding datapath (producer of FP32, consumer of words)
// slave : the packer itself
interface fp32_to_bf16_packer_if;
    localparam int unsigned FP32_W  = 32;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned LANES_W = 2;

    logic [FP32_W-1:0]  in_data;
    logic               in_valid;
    logic               in_ready;
    logic               flush;
    logic               flush_ack;
    logic [WORD_W-1:0]  out_word;
    logic [LANES_W-1:0] out_lanes;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_data, in_valid, flush, out_ready,
        input  in_ready, flush_ack, out_word, out_lanes, out_valid
    );

    modport slave (
        input  in_data, in_valid, flush, out_ready,
        output in_ready, flush_ack, out_word, out_lanes, out_valid
    );
endinterface

// File: rtl/fp32_to_bf16_packer.sv
// Rounds FP32 partial sums to BF16 (round-to-nearest-even) and packs two
// results per 32-bit word for the output SRAM.
// Ports:
//   clk         : rising-edge clock
//   rst         : synchronous active-low reset
//   bus         : slave side of fp32_to_bf16_packer_if (input stream,
//                 flush request/ack, packed output stream)
//   inexact_cnt : saturating count of accepted inputs that lost bits
// Parameter FTZ: 1 flushes FP32 exponent-0 inputs to signed zero.
module fp32_to_bf16_packer #(
    parameter bit FTZ = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    fp32_to_bf16_packer_if.slave   bus,
    output logic [15:0]            inexact_cnt
);
    localparam int unsigned BF16_W  = 16;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned LANES_W = 2;
    localparam int unsigned EXP_W   = 8;
    localparam int unsigned FRAC_W  = 23;
    localparam int unsigned CNT_W   = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } state_t;

    state_t              state;
    logic [BF16_W-1:0]   hold;
    logic [WORD_W-1:0]   out_word;
    logic [LANES_W-1:0]  out_lanes;
    logic                out_valid;

    logic                can_emit_c;
    logic                accept_c;
    logic                flush_ack_c;
    logic [BF16_W-1:0]   r_c;
    logic                inexact_c;

    logic                sign_c;
    logic [EXP_W-1:0]    exp_c;
    logic [FRAC_W-1:0]   frac_c;
    logic                round_up_c;

    // Output register is free when empty or being drained this cycle
    assign can_emit_c  = !out_valid || bus.out_ready;
    assign accept_c    = bus.in_valid && can_emit_c;
    assign flush_ack_c = bus.flush && can_emit_c;

    assign bus.in_ready  = can_emit_c;
    assign bus.flush_ack = flush_ack_c;
    assign bus.out_word  = out_word;
    assign bus.out_lanes = out_lanes;
    assign bus.out_valid = out_valid;

    // RNE narrowing with NaN/Inf/FTZ overrides and inexact detection
    always_comb begin
        sign_c     = bus.in_data[31];
        exp_c      = bus.in_data[30:23];
        frac_c     = bus.in_data[22:0];
        round_up_c = bus.in_data[15] && ((|bus.in_data[14:0]) || bus.in_data[16]);
        r_c        = bus.in_data[31:16] + BF16_W'(round_up_c);
        inexact_c  = (bus.in_data[15:0] != 16'h0000);

        if (exp_c == 8'hFF) begin
            // NaN is canonicalised to quiet; Inf keeps its sign
            r_c       = (frac_c != 23'd0) ? {sign_c, 8'hFF, 7'h40} : {sign_c, 8'hFF, 7'h00};
            inexact_c = 1'b0;
        end else if (FTZ && (exp_c == 8'h00)) begin
            r_c       = {sign_c, 15'h0000};
            inexact_c = (frac_c != 23'd0);
        end
    end

    // Pairing FSM, output register and inexact counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= EMPTY;
            hold        <= '0;
            out_word    <= '0;
            out_lanes   <= '0;
            out_valid   <= 1'b0;
            inexact_cnt <= '0;
        end else begin
            if (accept_c && inexact_c && (inexact_cnt != {CNT_W{1'b1}})) begin
                inexact_cnt <= inexact_cnt + CNT_W'(1);
            end

            // Drained word drops valid unless an emit below reloads it
            if (bus.out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                EMPTY: begin
                    if (accept_c) begin
                        if (bus.flush) begin
                            out_word  <= {16'h0000, r_c};
                            out_lanes <= 2'b01;
                            out_valid <= 1'b1;
                        end else begin
                            hold  <= r_c;
                            state <= HALF;
                        end
                    end
                end
                HALF: begin
                    // A flush alongside the completing input adds no word
                    if (accept_c) begin
                        out_word  <= {r_c, hold};
                        out_lanes <= 2'b11;
                        out_valid <= 1'b1;
                        state     <= EMPTY;
                    end else if (flush_ack_c) begin
                        out_word  <= {16'h0000, hold};
                        out_lanes <= 2'b01;
                        out_valid <= 1'b1;
                        state     <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_fp32_to_bf16_packer.sv
// Directed self-checking bench for fp32_to_bf16_packer (FTZ=1).
module tb_fp32_to_bf16_packer;
    logic        clk;
    logic        rst;
    logic [15:0] inexact_cnt;
    int          n_cmp;
    int          n_err;

    fp32_to_bf16_packer_if bus ();

    fp32_to_bf16_packer #(.FTZ(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .inexact_cnt (inexact_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then read 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one input for a single cycle (out_ready high, so in_ready is high)
    task automatic put(input logic [31:0] x);
        bus.in_valid = 1'b1;
        bus.in_data  = x;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic check_word(input string tag, input logic [31:0] w, input logic [1:0] lanes);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_word"},  bus.out_word, w);
        check({tag, "_lanes"}, 32'(bus.out_lanes), 32'(lanes));
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'h0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_word",  bus.out_word, 32'h0);
        check("rst_out_lanes", 32'(bus.out_lanes), 32'd0);
        check("rst_cnt",       32'(inexact_cnt), 32'd0);
        rst = 1'b1;
        tick();
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Pairing
        put(32'h3F800000);
        check("pair_no_emit", 32'(bus.out_valid), 32'd0);
        put(32'h40000000);
        check_word("pair", 32'h40003F80, 2'b11);
        tick();
        check("pair_one_cycle", 32'(bus.out_valid), 32'd0);
        check("pair_cnt", 32'(inexact_cnt), 32'd0);

        // Round-to-nearest-even
        put(32'h3F808000);
        put(32'h3F818000);
        check_word("rne0", 32'h3F823F80, 2'b11);
        put(32'h3F808001);
        put(32'h3F80FFFF);
        check_word("rne1", 32'h3F813F81, 2'b11);
        tick();
        check("rne_cnt", 32'(inexact_cnt), 32'd4);

        // Specials
        put(32'h7FC00001);
        put(32'h7F800001);
        check_word("nan", 32'h7FC07FC0, 2'b11);
        put(32'hFF800000);
        put(32'h7F7FFFFF);
        check_word("inf_ovf", 32'h7F80FF80, 2'b11);
        put(32'h80000001);
        bus.flush = 1'b1;
        #1;
        check("ftz_flush_ack", 32'(bus.flush_ack), 32'd1);
        tick();
        bus.flush = 1'b0;
        check_word("ftz", 32'h00008000, 2'b01);
        tick();
        check("spec_cnt", 32'(inexact_cnt), 32'd6);

        // Flush of a held half-word
        put(32'hC0400000);
        bus.flush = 1'b1;
        #1;
        check("half_flush_ack", 32'(bus.flush_ack), 32'd1);
        tick();
        bus.flush = 1'b0;
        check_word("half_flush", 32'h0000C040, 2'b01);
        tick();
        check("half_flush_drained", 32'(bus.out_valid), 32'd0);

        // Flush while EMPTY: ack, no word
        bus.flush = 1'b1;
        #1;
        check("empty_flush_ack", 32'(bus.flush_ack), 32'd1);
        tick();
        bus.flush = 1'b0;
        check("empty_flush_no_word", 32'(bus.out_valid), 32'd0);

        // Flush with the second input of a pair
        put(32'h3F800000);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h40000000;
        bus.flush    = 1'b1;
        #1;
        check("pair_flush_ack", 32'(bus.flush_ack), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        check_word("pair_flush", 32'h40003F80, 2'b11);
        tick();
        check("pair_flush_no_extra", 32'(bus.out_valid), 32'd0);

        // Back-to-back emits: accept+flush in EMPTY each cycle
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        bus.in_data  = 32'h3F800000;
        tick();
        check_word("b2b0", 32'h00003F80, 2'b01);
        bus.in_data  = 32'h40000000;
        tick();
        check_word("b2b1", 32'h00004000, 2'b01);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        tick();
        check("b2b_drained", 32'(bus.out_valid), 32'd0);

        // Backpressure
        put(32'h3F800000);
        put(32'h40400000);
        check_word("bp_word", 32'h40403F80, 2'b11);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h3F800000;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check_word("bp_hold", 32'h40403F80, 2'b11);
        end
        bus.flush = 1'b1;
        #1;
        check("bp_flush_ack", 32'(bus.flush_ack), 32'd0);
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check("bp_drained", 32'(bus.out_valid), 32'd0);
        bus.in_data = 32'h40800000;
        tick();
        bus.in_valid = 1'b0;
        check_word("bp_next", 32'h40803F80, 2'b11);
        tick();
        check("bp_no_extra", 32'(bus.out_valid), 32'd0);
        check("bp_cnt", 32'(inexact_cnt), 32'd6);

        // Reset while HALF discards the held value
        put(32'h3F800000);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_word",  bus.out_word, 32'h0);
        check("mid_rst_cnt",   32'(inexact_cnt), 32'd0);
        put(32'h40000000);
        check("mid_rst_no_emit", 32'(bus.out_valid), 32'd0);
        put(32'h40400000);
        check_word("mid_rst_pair", 32'h40404000, 2'b11);

        // Saturation of the inexact counter
        for (int i = 0; i < 65534; i++) begin
            put(32'h3F808001);
        end
        check("sat_fffe", 32'(inexact_cnt), 32'h0000FFFE);
        for (int i = 0; i < 6; i++) begin
            put(32'h3F808001);
        end
        check("sat_ffff", 32'(inexact_cnt), 32'h0000FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
